// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment constants and digit-count limits for the scan controller
package seg_pkg;

    localparam int NUM_DIGITS_MIN = 2;
    localparam int NUM_DIGITS_MAX = 16;

    // Active-low {g,f,e,d,c,b,a}; all ones turns every segment off.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Entry n holds the pattern for hex digit n.
    localparam logic [15:0][6:0] HEX_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - combinational hex nibble to active-low seven-segment decoder
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_TABLE[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed seven-segment scan controller; SEG_LEADING_ZERO_BLANK_EN enables leading-zero blanking
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int TICK_DIV   = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp_n
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]                 prescaler;
    logic [IW-1:0]                 idx;
    logic [NUM_DIGITS-1:0][3:0]    shadow_data;
    logic [NUM_DIGITS-1:0]         shadow_dp;
    logic                          tick;
    logic [3:0]                    cur_nibble;
    logic [6:0]                    cur_seg;
    logic                          lz_blank;
    logic                          lit;
    logic [NUM_DIGITS-1:0]         an_lit;

    assign tick       = (prescaler == PRE_LAST);
    assign cur_nibble = shadow_data[idx];

    hex7seg u_hex7seg (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic zero_run;

    // Walk down from the top digit; a digit is blanked while every nibble from it upward is zero.
    always_comb begin
        zero_run = 1'b1;
        lz_blank = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (shadow_data[i] == 4'h0);
            if (IW'(i) == idx && zero_run) begin
                lz_blank = 1'b1;
            end
        end
    end
`else
    assign lz_blank = 1'b0;
`endif

    // en and digit_en are live so blanking reacts within one edge, unlike data/dp.
    assign lit = en && digit_en[idx] && !lz_blank;

    always_comb begin
        an_lit      = '1;
        an_lit[idx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler   <= '0;
            idx         <= '0;
            shadow_data <= '0;
            shadow_dp   <= '0;
            an          <= '1;
            seg         <= SEG_BLANK;
            dp_n        <= 1'b1;
        end else begin
            if (tick) begin
                prescaler <= '0;
                if (idx == IDX_LAST) begin
                    idx         <= '0;
                    shadow_data <= data;
                    shadow_dp   <= dp;
                end else begin
                    idx <= idx + IW'(1);
                end
            end else begin
                prescaler <= prescaler + PW'(1);
            end

            if (lit) begin
                an   <= an_lit;
                seg  <= cur_seg;
                dp_n <= ~shadow_dp[idx];
            end else begin
                an   <= '1;
                seg  <= SEG_BLANK;
                dp_n <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl with NUM_DIGITS=4, TICK_DIV=4
module tb_seg_scan_ctrl;

    localparam int N    = 4;
    localparam int T    = 4;
    localparam int FR   = N * T;
    localparam int HMAX = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  digit_en = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;

    int   n_checks = 0;
    int   n_fail = 0;
    int   k = 0;
    logic rst_edge = 1'b1;

    logic [15:0] h_data [HMAX];
    logic [3:0]  h_dp   [HMAX];
    logic [3:0]  h_den  [HMAX];
    logic        h_en   [HMAX];

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic        en;
        logic [3:0]  den;
        int          slot;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dpn;
    } vec_t;

    vec_t vecs [10];

    seg_scan_ctrl #(.NUM_DIGITS(N), .TICK_DIV(T)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .data     (data),
        .dp       (dp),
        .digit_en (digit_en),
        .an       (an),
        .seg      (seg),
        .dp_n     (dp_n)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (k=%0d t=%0t)", name, act, exp, k, $time);
        end
    endtask

    task automatic step();
        if (k + 1 < HMAX) begin
            h_data[k+1] = data;
            h_dp[k+1]   = dp;
            h_den[k+1]  = digit_en;
            h_en[k+1]   = en;
        end
        rst_edge = rst;
        @(posedge clk);
        #1;
        if (rst_edge) k = 0;
        else k++;
    endtask

    // Outputs after edge k derive from slot position (k-1)/T and the data captured at the last frame boundary.
    task automatic check_model(input string name);
        int          idx;
        int          f;
        logic [15:0] sd;
        logic [3:0]  sp;
        logic        lit;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dpn;
        if (rst_edge) begin
            e_an  = 4'hF;
            e_seg = 7'h7F;
            e_dpn = 1'b1;
        end else begin
            idx = ((k - 1) / T) % N;
            f   = (k - 1) / FR;
            sd  = (f == 0) ? 16'h0 : h_data[f*FR];
            sp  = (f == 0) ? 4'h0 : h_dp[f*FR];
            lit = h_en[k] && h_den[k][idx];
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (idx != 0 && (sd >> (4 * idx)) == 16'h0) lit = 1'b0;
`endif
            e_an  = lit ? ~(4'b0001 << idx) : 4'hF;
            e_seg = lit ? ref_seg(sd[4*idx +: 4]) : 7'h7F;
            e_dpn = lit ? ~sp[idx] : 1'b1;
        end
        chk({name, "_an"}, 32'(an), 32'(e_an));
        chk({name, "_seg"}, 32'(seg), 32'(e_seg));
        chk({name, "_dpn"}, 32'(dp_n), 32'(e_dpn));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h8A31, 4'b0000, 1'b1, 4'b1111, 0, 4'b1110, 7'b1111001, 1'b1};
        vecs[1] = '{16'h8A31, 4'b0000, 1'b1, 4'b1111, 1, 4'b1101, 7'b0110000, 1'b1};
        vecs[2] = '{16'h8A31, 4'b0000, 1'b1, 4'b1111, 2, 4'b1011, 7'b0001000, 1'b1};
        vecs[3] = '{16'h8A31, 4'b0000, 1'b1, 4'b1111, 3, 4'b0111, 7'b0000000, 1'b1};
        vecs[4] = '{16'h8A31, 4'b0100, 1'b1, 4'b1111, 2, 4'b1011, 7'b0001000, 1'b0};
        vecs[5] = '{16'h8A31, 4'b0100, 1'b1, 4'b1111, 1, 4'b1101, 7'b0110000, 1'b1};
        vecs[6] = '{16'h8A31, 4'b0000, 1'b0, 4'b1111, 0, 4'b1111, 7'b1111111, 1'b1};
        vecs[7] = '{16'h8A31, 4'b0000, 1'b1, 4'b1011, 2, 4'b1111, 7'b1111111, 1'b1};
        vecs[8] = '{16'h8A31, 4'b0000, 1'b1, 4'b1011, 3, 4'b0111, 7'b0000000, 1'b1};
        vecs[9] = '{16'h8A31, 4'b0100, 1'b1, 4'b1011, 2, 4'b1111, 7'b1111111, 1'b1};

        // Reset and release.
        en = 1'b1; digit_en = 4'hF; data = 16'h8A31; dp = 4'h0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_an", 32'(an), 32'h0F);
            chk("rst_seg", 32'(seg), 32'h7F);
            chk("rst_dpn", 32'(dp_n), 32'h1);
        end
        rst = 1'b0;
        step();
        chk("rel_an", 32'(an), 32'(4'b1110));
        chk("rel_seg", 32'(seg), 32'(7'b1000000));
        chk("rel_dpn", 32'(dp_n), 32'h1);

        // Second-frame slot table.
        for (int v = 0; v < 10; v++) begin
            data = vecs[v].data; dp = vecs[v].dp; en = vecs[v].en; digit_en = vecs[v].den;
            do_reset();
            while (k < FR + vecs[v].slot * T) step();
            for (int c = 0; c < T; c++) begin
                step();
                chk($sformatf("vec%0d_an", v), 32'(an), 32'(vecs[v].e_an));
                chk($sformatf("vec%0d_seg", v), 32'(seg), 32'(vecs[v].e_seg));
                chk($sformatf("vec%0d_dpn", v), 32'(dp_n), 32'(vecs[v].e_dpn));
            end
        end

        // Mid-frame data change must not tear the frame being shown.
        data = 16'h8A31; dp = 4'h0; en = 1'b1; digit_en = 4'hF;
        do_reset();
        while (k < 3 * FR) begin
            step();
            check_model("tear");
            if (k == FR + T + 2) data = 16'hFFFF;
            if (k > FR + 2 * T && k <= FR + 3 * T) chk("tear_slot2", 32'(seg), 32'(7'b0001000));
            if (k > 2 * FR) chk("tear_next", 32'(seg), 32'(7'b0001110));
        end

        // Disable mid-frame: blank next edge, scan keeps moving.
        data = 16'h1234;
        for (int i = 0; i < 7; i++) begin
            if (i == 1) en = 1'b0;
            if (i == 5) en = 1'b1;
            step();
            check_model("en");
            if (i >= 1 && i < 5) chk("en_off_an", 32'(an), 32'h0F);
        end

`ifdef SEG_LEADING_ZERO_BLANK_EN
        data = 16'h0050; dp = 4'h0; en = 1'b1; digit_en = 4'hF;
        do_reset();
        while (k < 2 * FR) begin
            step();
            if (k > FR) begin
                case (((k - 1) / T) % N)
                    0: begin chk("lz50_an0", 32'(an), 32'(4'b1110)); chk("lz50_seg0", 32'(seg), 32'(7'b1000000)); end
                    1: begin chk("lz50_an1", 32'(an), 32'(4'b1101)); chk("lz50_seg1", 32'(seg), 32'(7'b0010010)); end
                    default: chk("lz50_off", 32'(an), 32'h0F);
                endcase
            end
        end
        data = 16'h0000;
        do_reset();
        while (k < 2 * FR) begin
            step();
            if (k > FR) begin
                if (((k - 1) / T) % N == 0) begin
                    chk("lz0_an0", 32'(an), 32'(4'b1110));
                    chk("lz0_seg0", 32'(seg), 32'(7'b1000000));
                end else begin
                    chk("lz0_off", 32'(an), 32'h0F);
                end
            end
        end
`endif

        // Randomized run including occasional mid-frame resets.
        for (int i = 0; i < 1200; i++) begin
            rst = ($urandom_range(0, 149) == 0) || (k > 1500);
            if ($urandom_range(0, 7) == 0) begin
                for (int d = 0; d < N; d++)
                    data[4*d +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 7) == 0) dp = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) en = ~en;
            if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom_range(0, 15));
            step();
            check_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
